// File: rtl/eros_obi_resp_pkg.sv
// eros_obi_resp_pkg: shared defaults, bus structs and response-pipeline entry for the OBI SRAM responder
package eros_obi_resp_pkg;
    localparam int unsigned DEPTH_DEF     = 256;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_0000;
    localparam int unsigned LATENCY_DEF   = 1;
    localparam int unsigned MAX_OUT_DEF   = 2;
    localparam logic [31:0] ERR_RDATA_DEF = 32'hBADC_AB1E;
    localparam int unsigned ADDR_IDX_W    = $clog2(DEPTH_DEF);
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;
    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } resp_entry_t;
endpackage

// File: rtl/eros_obi_resp_delay.sv
// eros_obi_resp_delay: LATENCY-deep response shift register with synchronous clear
//   clk_i, rst_i : clock, synchronous active-high clear of every stage
//   in_i         : entry pushed every cycle
//   out_o        : entry pushed LATENCY cycles earlier
module eros_obi_resp_delay
    import eros_obi_resp_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  resp_entry_t in_i,
    output resp_entry_t out_o
);
    resp_entry_t stage_q [LATENCY];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end
    assign out_o = stage_q[LATENCY-1];
endmodule

// File: rtl/eros_obi_sram_responder.sv
// eros_obi_sram_responder: OBI responder backed by a byte-enable SRAM with fixed response latency
//   clk_i, rst_i : clock, synchronous active-high reset
//   obi_req_i    : req/addr/we/be/wdata from the master
//   obi_resp_o   : gnt (combinational), rvalid/rdata LATENCY cycles after grant
//   err_o        : high in the grant cycle of an out-of-range access
//   txn_cnt_o    : saturating count of granted transactions
module eros_obi_sram_responder
    import eros_obi_resp_pkg::*;
#(
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned LATENCY   = LATENCY_DEF,
    parameter int unsigned MAX_OUT   = MAX_OUT_DEF,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  obi_req_t    obi_req_i,
    output obi_resp_t   obi_resp_o,
    output logic        err_o,
    output logic [15:0] txn_cnt_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             gnt;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [15:0]      txn_cnt_q, txn_cnt_d;
    resp_entry_t      push, pop;
    // addresses below BASE_ADDR are caught by the compare; the wrapped offset is never trusted alone
    assign offset   = obi_req_i.addr - BASE_ADDR;
    assign idx      = offset[IDX_W+1:2];
    assign in_range = (obi_req_i.addr >= BASE_ADDR) && (offset[31:IDX_W+2] == '0);
    assign gnt      = obi_req_i.req & ~rst_i & (out_cnt_q < CNT_W'(MAX_OUT));
    assign push     = '{valid: gnt,
                        data: (!gnt || obi_req_i.we) ? 32'd0 : (in_range ? mem_q[idx] : ERR_RDATA)};
    assign out_cnt_d = out_cnt_q + CNT_W'(gnt) - CNT_W'(pop.valid);
    assign txn_cnt_d = (gnt && txn_cnt_q != 16'hFFFF) ? txn_cnt_q + 16'd1 : txn_cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt_q <= '0;
            txn_cnt_q <= '0;
        end else begin
            out_cnt_q <= out_cnt_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (gnt && obi_req_i.we && in_range)
            for (int k = 0; k < 4; k++)
                if (obi_req_i.be[k]) mem_q[idx][8*k +: 8] <= obi_req_i.wdata[8*k +: 8];
    end
    eros_obi_resp_delay #(.LATENCY(LATENCY)) u_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (push),
        .out_o (pop)
    );
    assign obi_resp_o = '{gnt: gnt, rvalid: pop.valid, rdata: pop.data};
    assign err_o      = gnt & ~in_range;
    assign txn_cnt_o  = txn_cnt_q;
endmodule

// File: tb/tb_eros_obi_sram_responder.sv
// tb_eros_obi_sram_responder: directed vector and sequence bench for the OBI SRAM responder
module tb_eros_obi_sram_responder;
    import eros_obi_resp_pkg::*;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;
    localparam int NV = 17;
    logic        clk = 1'b0;
    logic        rst1, rst3, rst4;
    obi_req_t    r1, r3, r4;
    obi_resp_t   p1, p3, p4;
    logic        e1, e3, e4;
    logic [15:0] t1, t3, t4;
    int          total = 0;
    int          bad = 0;
    vec_t        v1 [NV];
    vec_t        s3 [16];
    int          g_cyc [16];
    int          r_cyc [16];
    logic        g_err [16];
    logic [31:0] r_dat [16];
    int          mx;
    int          eg [6] = '{0, 1, 4, 5, 8, 9};
    logic        seen;

    always #5 clk = ~clk;

    eros_obi_sram_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUT(1)) d1 (
        .clk_i(clk), .rst_i(rst1), .obi_req_i(r1), .obi_resp_o(p1), .err_o(e1), .txn_cnt_o(t1));
    eros_obi_sram_responder #(.DEPTH(256), .BASE_ADDR(32'h1000), .LATENCY(3), .MAX_OUT(2)) d3 (
        .clk_i(clk), .rst_i(rst3), .obi_req_i(r3), .obi_resp_o(p3), .err_o(e3), .txn_cnt_o(t3));
    eros_obi_sram_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .LATENCY(4), .MAX_OUT(2)) d4 (
        .clk_i(clk), .rst_i(rst4), .obi_req_i(r4), .obi_resp_o(p4), .err_o(e4), .txn_cnt_o(t4));

    task automatic chk1(input string n, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", n, act, exp);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] ex, input logic er);
        vec_t v;
        v = '{we, a, be, wd, ex, er};
        return v;
    endfunction

    function automatic obi_req_t mkreq(input vec_t v);
        return '{req: 1'b1, addr: v.addr, we: v.we, be: v.be, wdata: v.wdata};
    endfunction

    // holds req on d3 across the first n entries of s3, advancing on each grant
    task automatic run3(input int n);
        int gi;
        int ri;
        gi = 0;
        ri = 0;
        mx = 0;
        for (int c = 0; c < 100 && (gi < n || ri < n); c++) begin
            @(negedge clk);
            r3 = (gi < n) ? mkreq(s3[gi]) : '0;
            #1;
            if (p3.rvalid) begin
                if (ri < 16) begin
                    r_cyc[ri] = c;
                    r_dat[ri] = p3.rdata;
                end
                ri++;
            end
            if (p3.gnt && gi < n) begin
                g_cyc[gi] = c;
                g_err[gi] = e3;
                gi++;
            end
            if (gi - ri > mx) mx = gi - ri;
        end
        r3 = '0;
        chk32("run3_grants", 32'(gi), 32'(n));
        chk32("run3_rvalids", 32'(ri), 32'(n));
    endtask

    task automatic chk3(input int n);
        for (int i = 0; i < n; i++) begin
            chk32($sformatf("d3_rdata[%0d]", i), r_dat[i], s3[i].exp);
            chk1($sformatf("d3_err[%0d]", i), g_err[i], s3[i].exp_err);
            chk32($sformatf("d3_lat[%0d]", i), 32'(r_cyc[i] - g_cyc[i]), 32'd3);
        end
    endtask

    initial begin
        v1[0]  = mk(1, 32'h10,       4'hF, 32'hDEAD_BEEF, 32'h0,         0);
        v1[1]  = mk(0, 32'h10,       4'hF, 32'h0,         32'hDEAD_BEEF, 0);
        v1[2]  = mk(1, 32'h20,       4'hF, 32'h1122_3344, 32'h0,         0);
        v1[3]  = mk(1, 32'h20,       4'h5, 32'hAABB_CCDD, 32'h0,         0);
        v1[4]  = mk(0, 32'h22,       4'hF, 32'h0,         32'h11BB_33DD, 0);
        v1[5]  = mk(1, 32'h4,        4'hF, 32'h0BAD_F00D, 32'h0,         0);
        v1[6]  = mk(1, 32'h404,      4'hF, 32'h1234_5678, 32'h0,         1);
        v1[7]  = mk(0, 32'h4,        4'hF, 32'h0,         32'h0BAD_F00D, 0);
        v1[8]  = mk(0, 32'h400,      4'hF, 32'h0,         32'hBADC_AB1E, 1);
        v1[9]  = mk(1, 32'h3FC,      4'hF, 32'hCAFE_F00D, 32'h0,         0);
        v1[10] = mk(0, 32'h3FD,      4'hF, 32'h0,         32'hCAFE_F00D, 0);
        v1[11] = mk(1, 32'h10,       4'h8, 32'h7700_0000, 32'h0,         0);
        v1[12] = mk(0, 32'h10,       4'hF, 32'h0,         32'h77AD_BEEF, 0);
        v1[13] = mk(1, 32'hFFFF_FFFC, 4'hF, 32'h1,        32'h0,         1);
        v1[14] = mk(0, 32'h3FC,      4'hF, 32'h0,         32'hCAFE_F00D, 0);
        v1[15] = mk(1, 32'h20,       4'h0, 32'hFFFF_FFFF, 32'h0,         0);
        v1[16] = mk(0, 32'h20,       4'hF, 32'h0,         32'h11BB_33DD, 0);

        rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
        r1 = mkreq(mk(0, 32'h10, 4'hF, 32'h0, 32'h0, 0));
        r3 = '0;
        r4 = '0;
        repeat (2) @(negedge clk);
        #1 chk1("gnt_in_reset", p1.gnt, 1'b0);
        @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
        r1 = '0;
        #1;
        chk1("rst_gnt1", p1.gnt, 1'b0);
        chk1("rst_rvalid1", p1.rvalid, 1'b0);
        chk32("rst_rdata1", p1.rdata, 32'h0);
        chk1("rst_err1", e1, 1'b0);
        chk32("rst_txn1", 32'(t1), 32'h0);
        chk1("rst_rvalid3", p3.rvalid, 1'b0);
        chk32("rst_txn3", 32'(t3), 32'h0);
        chk1("rst_rvalid4", p4.rvalid, 1'b0);
        chk32("rst_txn4", 32'(t4), 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            r1 = mkreq(v1[i]);
            #1;
            chk1($sformatf("v%0d_gnt", i), p1.gnt, 1'b1);
            chk1($sformatf("v%0d_err", i), e1, v1[i].exp_err);
            @(negedge clk);
            r1 = '0;
            #1;
            chk1($sformatf("v%0d_rvalid", i), p1.rvalid, 1'b1);
            chk32($sformatf("v%0d_rdata", i), p1.rdata, v1[i].exp);
            chk32($sformatf("v%0d_txn", i), 32'(t1), 32'(i + 1));
        end

        @(negedge clk);
        r1 = mkreq(mk(1, 32'h30, 4'hF, 32'h600D_CAFE, 32'h0, 0));
        #1 chk1("mo1_wr_gnt", p1.gnt, 1'b1);
        @(negedge clk);
        r1 = mkreq(mk(0, 32'h30, 4'hF, 32'h0, 32'h0, 0));
        #1;
        chk1("mo1_blocked", p1.gnt, 1'b0);
        chk1("mo1_wr_rvalid", p1.rvalid, 1'b1);
        chk32("mo1_wr_rdata", p1.rdata, 32'h0);
        @(negedge clk);
        #1 chk1("mo1_rd_gnt", p1.gnt, 1'b1);
        chk1("mo1_idle_rvalid", p1.rvalid, 1'b0);
        chk32("mo1_idle_rdata", p1.rdata, 32'h0);
        @(negedge clk);
        r1 = '0;
        #1;
        chk1("mo1_rd_rvalid", p1.rvalid, 1'b1);
        chk32("mo1_rd_rdata", p1.rdata, 32'h600D_CAFE);
        chk32("mo1_txn", 32'(t1), 32'(NV + 2));

        @(negedge clk);
        force d1.txn_cnt_q = 16'hFFFE;
        @(negedge clk);
        release d1.txn_cnt_q;
        #1 chk32("sat_start", 32'(t1), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r1 = mkreq(mk(0, 32'h10, 4'hF, 32'h0, 32'h0, 0));
            #1 chk1($sformatf("sat_gnt%0d", i), p1.gnt, 1'b1);
            @(negedge clk);
            r1 = '0;
            #1 chk32($sformatf("sat_txn%0d", i), 32'(t1), 32'h0000_FFFF);
        end

        for (int k = 0; k < 6; k++)
            s3[k] = mk(1, 32'h1000 + 32'(4 * k), 4'hF, 32'h0A0B_0000 + 32'(k), 32'h0, 0);
        s3[6] = mk(1, 32'h1018, 4'hF, 32'h5A5A_1234, 32'h0, 0);
        s3[7] = mk(0, 32'h1018, 4'hF, 32'h0, 32'h5A5A_1234, 0);
        run3(8);
        chk3(8);
        chk32("d3_raw_b2b", 32'(g_cyc[7] - g_cyc[6]), 32'd1);

        for (int k = 0; k < 6; k++)
            s3[k] = mk(0, 32'h1000 + 32'(4 * k), 4'hF, 32'h0, 32'h0A0B_0000 + 32'(k), 0);
        run3(6);
        chk3(6);
        for (int i = 0; i < 6; i++)
            chk32($sformatf("burst_gcyc[%0d]", i), 32'(g_cyc[i]), 32'(eg[i]));
        chk32("burst_max_out", 32'(mx), 32'd2);

        s3[0] = mk(0, 32'h0FFC, 4'hF, 32'h0,         32'hBADC_AB1E, 1);
        s3[1] = mk(1, 32'h1400, 4'hF, 32'hFFFF_FFFF, 32'h0,         1);
        s3[2] = mk(0, 32'h1000, 4'hF, 32'h0,         32'h0A0B_0000, 0);
        run3(3);
        chk3(3);

        @(negedge clk);
        r4 = mkreq(mk(1, 32'h8, 4'hF, 32'h1357_9BDF, 32'h0, 0));
        #1 chk1("r4_wr_gnt", p4.gnt, 1'b1);
        @(negedge clk);
        r4 = '0;
        repeat (5) @(negedge clk);
        r4 = mkreq(mk(0, 32'h8, 4'hF, 32'h0, 32'h0, 0));
        #1 chk1("r4_rd_gnt", p4.gnt, 1'b1);
        @(negedge clk);
        r4 = '0;
        @(negedge clk);
        rst4 = 1'b1;
        r4 = mkreq(mk(1, 32'h8, 4'hF, 32'hFFFF_FFFF, 32'h0, 0));
        #1 chk1("r4_rst_gnt", p4.gnt, 1'b0);
        @(negedge clk);
        rst4 = 1'b0;
        r4 = '0;
        #1;
        chk1("r4_post_gnt", p4.gnt, 1'b0);
        chk1("r4_post_rvalid", p4.rvalid, 1'b0);
        chk32("r4_post_rdata", p4.rdata, 32'h0);
        chk1("r4_post_err", e4, 1'b0);
        chk32("r4_post_txn", 32'(t4), 32'h0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1 if (p4.rvalid) seen = 1'b1;
        end
        chk1("r4_dropped", seen, 1'b0);
        @(negedge clk);
        r4 = mkreq(mk(0, 32'h8, 4'hF, 32'h0, 32'h0, 0));
        #1 chk1("r4_next_gnt", p4.gnt, 1'b1);
        @(negedge clk);
        r4 = '0;
        @(negedge clk);
        @(negedge clk);
        #1 chk1("r4_early", p4.rvalid, 1'b0);
        @(negedge clk);
        #1;
        chk1("r4_rvalid", p4.rvalid, 1'b1);
        chk32("r4_rdata", p4.rdata, 32'h1357_9BDF);
        chk32("r4_txn", 32'(t4), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
